// File: rtl/tbus_pkg.sv
// Shared tbus types: arbiter states, requester ids, widths and op codes.
// Included by the arbiter and its picker through import tbus_pkg::*.
package tbus_pkg;

  localparam int RESULT_WIDTH      = 64;
  localparam int SRC_WIDTH         = 64;
  localparam int TBUS_MASK_WIDTH   = 64;
  localparam int TBUS_OPTYPE_WIDTH = 2;

  typedef logic [TBUS_OPTYPE_WIDTH-1:0] tbus_optype_t;

  localparam tbus_optype_t TBUS_READ  = 2'd0;
  localparam tbus_optype_t TBUS_WRITE = 2'd1;

  localparam logic TBUS_REQ_FETCH = 1'b0;
  localparam logic TBUS_REQ_LSU   = 1'b1;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    PENDING     = 2'b01,
    OUTSTANDING = 2'b10
  } tbus_arb_state_t;

  typedef struct packed {
    logic [RESULT_WIDTH-1:0]    index;
    logic [SRC_WIDTH-1:0]       write_data;
    logic [TBUS_MASK_WIDTH-1:0] write_mask;
    tbus_optype_t               operation_type;
  } tbus_req_t;

  function automatic logic is_contended(input logic [1:0] valid);
    return valid[0] & valid[1];
  endfunction

endpackage

// File: rtl/tbus_arb_pick.sv
// Combinational two-way picker for the tbus arbiter.
// TBUS_ARB_RR_EN selects round-robin; otherwise memblock has fixed priority.
module tbus_arb_pick
  import tbus_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       sel
);

`ifdef TBUS_ARB_RR_EN
  always_comb begin
    sel = valid[TBUS_REQ_LSU];
    if (is_contended(valid)) begin
      sel = ~last_grant;
    end
  end
`else
  logic unused_last_grant;

  assign unused_last_grant = last_grant;

  always_comb begin
    sel = TBUS_REQ_FETCH;
    if (valid[TBUS_REQ_LSU]) begin
      sel = TBUS_REQ_LSU;
    end
  end
`endif

endmodule

// File: rtl/tbus_arbiter.sv
// Two-requester arbiter/sequencer for the single tbus channel, one op at a time.
// Build option: define TBUS_ARB_RR_EN for round-robin, else memblock priority.
module tbus_arbiter
  import tbus_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = RESULT_WIDTH
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NREQ-1:0]                        req_valid,
  output logic [NREQ-1:0]                        req_ready,
  input  logic [NREQ-1:0][IDX_W-1:0]             req_index,
  input  logic [NREQ-1:0][SRC_WIDTH-1:0]         req_write_data,
  input  logic [NREQ-1:0][TBUS_MASK_WIDTH-1:0]   req_write_mask,
  input  logic [NREQ-1:0][TBUS_OPTYPE_WIDTH-1:0] req_operation_type,
  output logic [NREQ-1:0]                        resp_done,
  output logic [IDX_W-1:0]                       resp_read_data,
  output logic                                   tbus_index_valid,
  input  logic                                   tbus_index_ready,
  output logic [IDX_W-1:0]                       tbus_index,
  output logic [SRC_WIDTH-1:0]                   tbus_write_data,
  output logic [TBUS_MASK_WIDTH-1:0]             tbus_write_mask,
  output logic [TBUS_OPTYPE_WIDTH-1:0]           tbus_operation_type,
  input  logic [IDX_W-1:0]                       tbus_read_data,
  input  logic                                   tbus_operation_done
);

  tbus_arb_state_t state;
  tbus_arb_state_t state_nxt;
  logic            owner;
  logic            owner_nxt;
  logic            last_grant;
  logic            last_grant_nxt;

  logic      sel;
  logic      gnt;
  logic      gnt_vld;
  logic      fire;
  logic      done_ok;
  tbus_req_t fwd;

  tbus_arb_pick u_pick (
    .valid      (req_valid),
    .last_grant (last_grant),
    .sel        (sel)
  );

  always_comb begin
    gnt     = owner;
    gnt_vld = 1'b0;
    unique case (state)
      IDLE: begin
        gnt     = sel;
        gnt_vld = |req_valid;
      end
      PENDING: begin
        gnt     = owner;
        gnt_vld = req_valid[owner];
      end
      OUTSTANDING: begin
        gnt     = owner;
        gnt_vld = 1'b0;
      end
      default: begin
        gnt     = owner;
        gnt_vld = 1'b0;
      end
    endcase
    if (reset) begin
      gnt_vld = 1'b0;
    end
  end

  assign fire    = gnt_vld & tbus_index_ready;
  assign done_ok = ~reset & (state == OUTSTANDING)
                 & tbus_operation_done;

  // Non-forwarded cycles drive an all-zero bundle onto the bus.
  always_comb begin
    fwd = '0;
    if (gnt_vld) begin
      fwd.index          = req_index[gnt];
      fwd.write_data     = req_write_data[gnt];
      fwd.write_mask     = req_write_mask[gnt];
      fwd.operation_type = req_operation_type[gnt];
    end
  end

  assign tbus_index_valid    = gnt_vld;
  assign tbus_index          = fwd.index;
  assign tbus_write_data     = fwd.write_data;
  assign tbus_write_mask     = fwd.write_mask;
  assign tbus_operation_type = fwd.operation_type;

  always_comb begin
    req_ready = '0;
    if (fire) begin
      req_ready[gnt] = 1'b1;
    end
  end

  always_comb begin
    resp_done = '0;
    if (done_ok) begin
      resp_done[owner] = 1'b1;
    end
  end

  assign resp_read_data = reset ? '0 : tbus_read_data;

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    if (fire) begin
      last_grant_nxt = gnt;
    end
    unique case (state)
      IDLE: begin
        if (gnt_vld) begin
          owner_nxt = sel;
          state_nxt = fire ? OUTSTANDING : PENDING;
        end
      end
      PENDING: begin
        if (!req_valid[owner]) begin
          state_nxt = IDLE;
        end else if (fire) begin
          state_nxt = OUTSTANDING;
        end
      end
      OUTSTANDING: begin
        if (tbus_operation_done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= TBUS_REQ_FETCH;
      last_grant <= TBUS_REQ_FETCH;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
    end
  end

endmodule

// File: tb/tb_tbus_arbiter.sv
// Self-checking bench for tbus_arbiter: vector table, corner sequences,
// and random traffic against a transaction-level reference model.
module tb_tbus_arbiter;
  import tbus_pkg::*;

  logic                    clock;
  logic                    reset;
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0][63:0]        req_index;
  logic [1:0][63:0]        req_write_data;
  logic [1:0][63:0]        req_write_mask;
  logic [1:0][1:0]         req_operation_type;
  logic [1:0]              resp_done;
  logic [63:0]             resp_read_data;
  logic                    tbus_index_valid;
  logic                    tbus_index_ready;
  logic [63:0]             tbus_index;
  logic [63:0]             tbus_write_data;
  logic [63:0]             tbus_write_mask;
  logic [1:0]              tbus_operation_type;
  logic [63:0]             tbus_read_data;
  logic                    tbus_operation_done;

  int total;
  int bad;

  tbus_arbiter dut (
    .clock               (clock),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_index           (req_index),
    .req_write_data      (req_write_data),
    .req_write_mask      (req_write_mask),
    .req_operation_type  (req_operation_type),
    .resp_done           (resp_done),
    .resp_read_data      (resp_read_data),
    .tbus_index_valid    (tbus_index_valid),
    .tbus_index_ready    (tbus_index_ready),
    .tbus_index          (tbus_index),
    .tbus_write_data     (tbus_write_data),
    .tbus_write_mask     (tbus_write_mask),
    .tbus_operation_type (tbus_operation_type),
    .tbus_read_data      (tbus_read_data),
    .tbus_operation_done (tbus_operation_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: bus free / claimed-but-unaccepted / in flight.
  int m_phase;
  int m_who;
  int m_last;
  int m_f;
  logic [1:0] m_acc;

  function automatic int m_pick(input logic [1:0] v);
    if (v == 2'b11) begin
`ifdef TBUS_ARB_RR_EN
      return 1 - m_last;
`else
      return 1;
`endif
    end
    if (v[1]) return 1;
    if (v[0]) return 0;
    return -1;
  endfunction

  function automatic int m_fwd();
    if (m_phase == 0) return m_pick(req_valid);
    if (m_phase == 1) return req_valid[m_who] ? m_who : -1;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic settle_check();
    int f;
    logic       ev;
    logic [1:0] er;
    logic [1:0] ed;
    logic [63:0] ei;
    logic [63:0] ew;
    logic [63:0] em;
    logic [1:0]  eo;
    logic [63:0] erd;
    #1;
    ev = 0; er = 0; ed = 0; ei = 0; ew = 0; em = 0; eo = 0; erd = 0;
    f = -1;
    if (!reset) begin
      f = m_fwd();
      if (f >= 0) begin
        ev = 1'b1;
        ei = req_index[f];
        ew = req_write_data[f];
        em = req_write_mask[f];
        eo = req_operation_type[f];
        er[f] = tbus_index_ready;
      end
      if (m_phase == 2 && tbus_operation_done) ed[m_who] = 1'b1;
      erd = tbus_read_data;
    end
    m_f = f;
    m_acc = er;
    chk("ctl", {251'd0, tbus_index_valid, req_ready, resp_done},
        {251'd0, ev, er, ed});
    chk("payload", {62'd0, tbus_index, tbus_write_data, tbus_write_mask,
        tbus_operation_type}, {62'd0, ei, ew, em, eo});
    chk("rdata", {192'd0, resp_read_data}, {192'd0, erd});
  endtask

  task automatic tick();
    logic rdy;
    logic dn;
    logic rs;
    rdy = tbus_index_ready;
    dn = tbus_operation_done;
    rs = reset;
    @(posedge clock);
    if (rs) begin
      m_phase = 0; m_who = 0; m_last = 0;
    end else begin
      case (m_phase)
        0: if (m_f >= 0) begin
             m_who = m_f;
             m_phase = rdy ? 2 : 1;
           end
        1: if (m_f < 0) m_phase = 0;
           else if (rdy) m_phase = 2;
        default: if (dn) m_phase = 0;
      endcase
      if (m_f >= 0 && rdy) m_last = m_f;
    end
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 2'b00;
    tbus_index_ready = 1'b0;
    tbus_operation_done = 1'b0;
    tbus_read_data = '0;
    for (int i = 0; i < 2; i++) begin
      req_index[i] = '0;
      req_write_data[i] = '0;
      req_write_mask[i] = '0;
      req_operation_type[i] = TBUS_READ;
    end
  endtask

  typedef struct {
    logic [1:0]  v;
    logic        rdy;
    logic        dn;
    logic [63:0] i0;
    logic [63:0] i1;
    logic [63:0] rd;
    logic        ev;
    logic [63:0] eidx;
    logic [1:0]  erdy;
    logic [1:0]  edone;
  } vec_t;

`ifdef TBUS_ARB_RR_EN
  localparam logic [63:0] I7 = 64'h10;
  localparam logic [1:0]  R7 = 2'b01;
  localparam logic [1:0]  V8 = 2'b10;
  localparam logic [1:0]  D8 = 2'b01;
  localparam logic [63:0] I9 = 64'h30;
`else
  localparam logic [63:0] I7 = 64'h30;
  localparam logic [1:0]  R7 = 2'b10;
  localparam logic [1:0]  V8 = 2'b01;
  localparam logic [1:0]  D8 = 2'b10;
  localparam logic [63:0] I9 = 64'h40;
`endif

  vec_t vt[10];

  initial begin
    total = 0;
    bad = 0;
    m_phase = 0; m_who = 0; m_last = 0; m_f = -1; m_acc = 0;
    idle_inputs();
    reset = 1'b1;
    req_valid = 2'b11;
    tbus_index_ready = 1'b1;
    tbus_operation_done = 1'b1;
    tbus_read_data = 64'h55;
    settle_check();
    tick();
    tick();
    idle_inputs();
    reset = 1'b0;
    #1;

    vt[0] = '{2'b01, 1, 0, 64'h8000_0000, 0, 0,
              1, 64'h8000_0000, 2'b01, 2'b00};
    vt[1] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    vt[2] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    vt[3] = '{2'b00, 0, 1, 0, 0, 64'hDEAD_BEEF,
              0, 0, 2'b00, 2'b01};
    vt[4] = '{2'b11, 1, 0, 64'h10, 64'h20, 0,
              1, 64'h20, 2'b10, 2'b00};
    vt[5] = '{2'b01, 1, 1, 64'h10, 0, 0, 0, 0, 2'b00, 2'b10};
    vt[6] = '{2'b11, 1, 0, 64'h10, 64'h30, 0, 1, I7, R7, 2'b00};
    vt[7] = '{V8, 0, 1, 64'h10, 64'h30, 0, 0, 0, 2'b00, D8};
    vt[8] = '{2'b11, 1, 0, 64'h10, I9, 0, 1, I9, 2'b10, 2'b00};
    vt[9] = '{2'b01, 0, 1, 64'h10, 0, 0, 0, 0, 2'b00, 2'b10};

    for (int k = 0; k < 10; k++) begin
      req_valid = vt[k].v;
      tbus_index_ready = vt[k].rdy;
      tbus_operation_done = vt[k].dn;
      req_index[0] = vt[k].i0;
      req_index[1] = vt[k].i1;
      tbus_read_data = vt[k].rd;
      settle_check();
      chk($sformatf("vec%0d_v", k), {255'd0, tbus_index_valid},
          {255'd0, vt[k].ev});
      chk($sformatf("vec%0d_idx", k), {192'd0, tbus_index},
          {192'd0, vt[k].eidx});
      chk($sformatf("vec%0d_rdy", k), {254'd0, req_ready},
          {254'd0, vt[k].erdy});
      chk($sformatf("vec%0d_done", k), {254'd0, resp_done},
          {254'd0, vt[k].edone});
      if (k == 3) begin
        chk("single_rdata", {192'd0, resp_read_data},
            {192'd0, 64'hDEAD_BEEF});
      end
      tick();
    end
    idle_inputs();
    tick();

    // Pending lock: fetch waits on ready, memblock cannot steal.
    req_valid = 2'b01;
    req_index[0] = 64'h100;
    req_index[1] = 64'h500;
    for (int c = 0; c < 4; c++) begin
      if (c >= 2) req_valid = 2'b11;
      settle_check();
      chk("lock_idx", {192'd0, tbus_index}, {192'd0, 64'h100});
      chk("lock_rdy", {254'd0, req_ready}, {254'd0, 2'b00});
      tick();
    end
    tbus_index_ready = 1'b1;
    settle_check();
    chk("lock_fire", {254'd0, req_ready}, {254'd0, 2'b01});
    chk("lock_fire_idx", {192'd0, tbus_index}, {192'd0, 64'h100});
    tick();
    req_valid = 2'b10;
    tbus_operation_done = 1'b1;
    settle_check();
    chk("lock_done", {254'd0, resp_done}, {254'd0, 2'b01});
    tick();
    tbus_operation_done = 1'b0;
    settle_check();
    chk("lock_next_idx", {192'd0, tbus_index}, {192'd0, 64'h500});
    tick();
    req_valid = 2'b00;
    tbus_operation_done = 1'b1;
    settle_check();
    tick();
    idle_inputs();

    // Abandon: memblock drops while pending, then fetch goes through.
    req_valid = 2'b10;
    req_index[1] = 64'h300;
    settle_check();
    tick();
    req_valid = 2'b00;
    settle_check();
    chk("abandon_v", {255'd0, tbus_index_valid}, {255'd0, 1'b0});
    tick();
    req_valid = 2'b01;
    req_index[0] = 64'h200;
    tbus_index_ready = 1'b1;
    settle_check();
    chk("abandon_idx", {192'd0, tbus_index}, {192'd0, 64'h200});
    chk("abandon_rdy", {254'd0, req_ready}, {254'd0, 2'b01});
    tick();
    idle_inputs();
    tbus_operation_done = 1'b1;
    settle_check();
    chk("abandon_done", {254'd0, resp_done}, {254'd0, 2'b01});
    tick();
    idle_inputs();

    // Write passthrough from memblock.
    req_valid = 2'b10;
    req_index[1] = 64'h1000;
    req_write_data[1] = 64'hAB00;
    req_write_mask[1] = 64'hFF00;
    req_operation_type[1] = TBUS_WRITE;
    tbus_index_ready = 1'b1;
    settle_check();
    chk("wr_op", {254'd0, tbus_operation_type}, {254'd0, TBUS_WRITE});
    chk("wr_mask", {192'd0, tbus_write_mask}, {192'd0, 64'hFF00});
    chk("wr_data", {192'd0, tbus_write_data}, {192'd0, 64'hAB00});
    tick();
    idle_inputs();
    tbus_operation_done = 1'b1;
    settle_check();
    chk("wr_done", {254'd0, resp_done}, {254'd0, 2'b10});
    tick();
    idle_inputs();

    // Reset while outstanding, then a stale done.
    req_valid = 2'b01;
    req_index[0] = 64'h40;
    tbus_index_ready = 1'b1;
    settle_check();
    tick();
    reset = 1'b1;
    req_valid = 2'b11;
    tbus_operation_done = 1'b1;
    tbus_read_data = 64'h1234;
    settle_check();
    chk("rst_outs", {59'd0, tbus_index_valid, req_ready, resp_done,
        resp_read_data, tbus_index}, 256'd0);
    tick();
    idle_inputs();
    reset = 1'b0;
    tbus_operation_done = 1'b1;
    settle_check();
    chk("stale_done", {254'd0, resp_done}, {254'd0, 2'b00});
    tick();
    idle_inputs();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (m_acc[i]) begin
          req_valid[i] = 1'b0;
        end else if (req_valid[i] && $urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_index[i] = {$urandom, $urandom};
          req_write_data[i] = {$urandom, $urandom};
          req_write_mask[i] = {$urandom, $urandom};
          req_operation_type[i] = (i == 1 && $urandom_range(0, 1) == 1)
                                  ? TBUS_WRITE : TBUS_READ;
        end
      end
      tbus_index_ready = ($urandom_range(0, 1) == 1);
      tbus_operation_done = ($urandom_range(0, 2) == 0);
      tbus_read_data = {$urandom, $urandom};
      reset = ($urandom_range(0, 99) == 0);
      settle_check();
      tick();
      reset = 1'b0;
      if (m_phase == 0 && m_f < 0) m_acc = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
